// File: rtl/md5_hbf_pkg.sv
// md5_hbf_pkg: shared digest sizes and UART receive FSM states.
package md5_hbf_pkg;
  localparam int DIGEST_BYTES = 16;
  localparam int DIGEST_WIDTH = 128;
  localparam int TIMEOUT_BITS = 20;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronizes rxd and receives 8N1 bytes, strobing each on its stop-bit sample.
module uart_rx_byte
  import md5_hbf_pkg::*;
#(
  parameter int clock_freq = 50000000,
  parameter int baud_rate  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       framing_error,
  output logic       idle
);
  localparam int DIV = clock_freq / baud_rate;
  localparam int CW = $clog2(DIV + 1);
  logic [1:0] sync;
  logic rxs, rxs_d, expire, ferr_n;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  assign rxs = sync[1];
  assign expire = cnt == '0;
  assign byte_data = shift;
  assign idle = state == RX_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= 2'b11;
      rxs_d <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      framing_error <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      rxs_d <= rxs;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      framing_error <= ferr_n;
    end
  end
  // A load of N-1 puts the sample N cycles after the loading cycle.
  always_comb begin
    state_n = state;
    cnt_n = expire ? cnt : cnt - 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    byte_strobe = 1'b0;
    ferr_n = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = RX_START;
          cnt_n = CW'(DIV / 2 - 1);
        end
      end
      RX_START: begin
        if (expire) begin
          state_n = rxs ? RX_IDLE : RX_DATA;
          cnt_n = CW'(DIV - 1);
          bit_idx_n = '0;
        end
      end
      RX_DATA: begin
        if (expire) begin
          shift_n = {rxs, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          cnt_n = CW'(DIV - 1);
          state_n = bit_idx == 3'd7 ? RX_STOP : RX_DATA;
        end
      end
      default: begin
        if (expire) begin
          state_n = RX_IDLE;
          byte_strobe = rxs;
          ferr_n = !rxs;
        end
      end
    endcase
  end
endmodule

// File: rtl/uart_digest_rx.sv
// uart_digest_rx: assembles 16 UART bytes into a 128-bit digest; UART_DIGEST_TIMEOUT_EN adds an idle timeout on partial digests.
module uart_digest_rx
  import md5_hbf_pkg::*;
#(
  parameter int clock_freq = 50000000,
  parameter int baud_rate  = 115200
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    rxd,
  output logic [DIGEST_WIDTH-1:0] digest,
  output logic                    digest_valid,
  output logic                    framing_error,
  output logic [3:0]              byte_index
);
  localparam int DIV = clock_freq / baud_rate;
  logic [7:0] byte_data;
  logic byte_strobe, rx_idle, time_up;
  logic [DIGEST_WIDTH-1:0] shadow, shadow_n;
  uart_rx_byte #(.clock_freq(clock_freq), .baud_rate(baud_rate)) u_rx (
    .clock(clock),
    .reset(reset),
    .rxd(rxd),
    .byte_data(byte_data),
    .byte_strobe(byte_strobe),
    .framing_error(framing_error),
    .idle(rx_idle)
  );
  // Byte k lands at bits [127-8k -: 8]; 15-k equals ~k for a 4-bit index.
  always_comb begin
    shadow_n = shadow;
    shadow_n[{~byte_index, 3'b000} +: 8] = byte_data;
  end
`ifdef UART_DIGEST_TIMEOUT_EN
  localparam int TO = TIMEOUT_BITS * DIV;
  localparam int TW = $clog2(TO + 1);
  logic [TW-1:0] idle_cnt;
  always_ff @(posedge clock) begin
    if (reset || !rx_idle || byte_index == '0) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
  end
  assign time_up = idle_cnt == TW'(TO - 1);
`else
  assign time_up = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      digest <= '0;
      digest_valid <= 1'b0;
      byte_index <= '0;
      shadow <= '0;
    end else begin
      digest_valid <= 1'b0;
      if (clear || framing_error || time_up) byte_index <= '0;
      else if (byte_strobe) begin
        shadow <= shadow_n;
        byte_index <= byte_index + 1'b1;
        if (byte_index == 4'(DIGEST_BYTES - 1)) begin
          digest <= shadow_n;
          digest_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_digest_rx.sv
// tb_uart_digest_rx: random and directed UART frames checked against a byte-queue digest model.
module tb_uart_digest_rx;
  localparam int CF = 1600000;
  localparam int BR = 100000;
  localparam int DIV = CF / BR;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic rxd = 1'b1;
  logic [127:0] digest;
  logic digest_valid, framing_error;
  logic [3:0] byte_index;
  int total = 0, bad = 0, cyc = 0, vcnt = 0, fcnt = 0, exp_v = 0, exp_f = 0, last_v = 0, unstable = 0;
  logic [127:0] prev_digest = '0, model_digest = '0;
  logic [7:0] q[$];

  uart_digest_rx #(.clock_freq(CF), .baud_rate(BR)) dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .rxd(rxd),
    .digest(digest),
    .digest_valid(digest_valid),
    .framing_error(framing_error),
    .byte_index(byte_index)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (digest_valid) begin
      vcnt++;
      last_v = cyc;
    end
    if (framing_error) fcnt++;
    if (!reset && !digest_valid && digest !== prev_digest) unstable++;
    prev_digest = digest;
  end

  initial begin
    #2000000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
`ifdef UART_DIGEST_TIMEOUT_EN
    if (n > 20 * DIV) q.delete();
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    int t0;
    t0 = cyc;
    rxd = 1'b0;
    repeat (DIV) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(posedge clock);
    end
    rxd = stop;
    repeat (DIV) @(posedge clock);
    #1;
    if (stop) begin
      q.push_back(b);
      if (q.size() == 16) begin
        for (int i = 0; i < 16; i++) model_digest[127 - 8 * i -: 8] = q[i];
        q.delete();
        exp_v++;
        check("digest", digest, model_digest);
        check("latency", 128'((last_v - t0) >= DIV / 2 + 9 * DIV + 2 && (last_v - t0) <= DIV / 2 + 9 * DIV + 4), 128'(1));
      end
    end else begin
      q.delete();
      exp_f++;
      rxd = 1'b1;
      wait_cycles(DIV);
    end
    check("byte_index", 128'(byte_index), 128'(q.size()));
    check("valid_count", 128'(vcnt), 128'(exp_v));
    check("ferr_count", 128'(fcnt), 128'(exp_f));
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), 1'b1);
      wait_cycles($urandom_range(0, 3));
    end
  endtask

  task automatic send_const(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_digest", digest, 128'h0);
    check("rst_valid", 128'(digest_valid), 128'h0);
    check("rst_ferr", 128'(framing_error), 128'h0);
    check("rst_index", 128'(byte_index), 128'h0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    check("seq_digest", digest, 128'h000102030405060708090A0B0C0D0E0F);
    send_rand(2);
    send_byte(8'h55, 1'b0);
    check("ferr_index", 128'(byte_index), 128'h0);
    send_const(8'hA5, 16);
    check("a5_digest", digest, {16{8'hA5}});
    send_rand(5);
    rxd = 1'b0;
    repeat (DIV / 4) @(posedge clock);
    #1;
    rxd = 1'b1;
    wait_cycles(2 * DIV);
    check("glitch_index", 128'(byte_index), 128'd5);
    check("glitch_valid", 128'(vcnt), 128'(exp_v));
    check("glitch_ferr", 128'(fcnt), 128'(exp_f));
    send_rand(3);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    q.delete();
    check("clear_index", 128'(byte_index), 128'h0);
    send_const(8'h3C, 16);
    check("clear_digest", digest, {16{8'h3C}});
    send_rand(8);
    wait_cycles(25 * DIV);
    send_const(8'h11, 16);
`ifdef UART_DIGEST_TIMEOUT_EN
    check("timeout_digest", digest, {16{8'h11}});
    check("timeout_index", 128'(byte_index), 128'h0);
`else
    check("persist_low", 128'(digest[63:0]), 128'({8{8'h11}}));
    check("persist_index", 128'(byte_index), 128'd8);
`endif
    send_rand(2);
    rxd = 1'b0;
    repeat (DIV) @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'($urandom);
      repeat (DIV) @(posedge clock);
    end
    rxd = 1'b0;
    repeat (DIV / 2) @(posedge clock);
    #1;
    reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    model_digest = '0;
    check("midrst_digest", digest, 128'h0);
    check("midrst_index", 128'(byte_index), 128'h0);
    wait_cycles(2 * DIV);
    send_rand(16);
    check("final_stable", 128'(unstable), 128'h0);
    check("final_valid", 128'(vcnt), 128'(exp_v));
    check("final_ferr", 128'(fcnt), 128'(exp_f));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
